// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit buffer.
//   UART_DATA_W  - byte width handed to the transmitter
//   GUARD_CYCLES - cycles spent in S_WAIT_LOW before giving up on a lost handshake
//   tx_state_t   - launch FSM state encoding
package uart_pkg;

    localparam int UART_DATA_W  = 8;
    localparam int GUARD_CYCLES = 2;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_LOW  = 2'd2,
        S_WAIT_HIGH = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Circular synchronous FIFO with show-ahead read data.
//   clk, rst_n - clock, asynchronous active-low reset
//   flush      - synchronous clear of pointers and level (beats push/pop)
//   push, din  - enqueue din when not full (or when a pop frees a slot this cycle)
//   pop        - dequeue head entry; ignored when empty
//   dout       - head entry, mem[rd_ptr]
//   level      - entries stored, 0..2^ADDR_W
//   full/empty - level == 2^ADDR_W / level == 0
module sync_fifo #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full  = (level == DEPTH);
    assign empty = (level == '0);
    assign dout  = mem[rd_ptr];

    // A pop in the same cycle frees a slot, so a push at full still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer and pacing stage in front of the UART transmitter.
//   clk, rst_n         - clock, asynchronous active-low reset
//   flush              - clears FIFO contents and overflow; a frame in flight completes
//   wr_en, wr_data     - one byte per cycle from the bus side
//   full, empty, level - FIFO occupancy
//   overflow           - sticky, set by a write that found the FIFO full
//   tx_data            - byte presented to the transmitter, held until the next launch
//   tx_data_valid      - one-cycle launch pulse
//   tx_data_ready      - transmitter idle indication
//   busy               - FIFO not empty or a frame in flight
//
// state       | meaning
// S_IDLE      | waiting for data and an idle transmitter
// S_LAUNCH    | tx_data_valid high for this single cycle
// S_WAIT_LOW  | waiting for ready to drop (byte accepted); guarded timeout
// S_WAIT_HIGH | frame on the line, waiting for ready to return
import uart_pkg::*;

module uart_tx_fifo #(
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        level,
    output logic                   overflow,
    output logic [UART_DATA_W-1:0] tx_data,
    output logic                   tx_data_valid,
    input  logic                   tx_data_ready,
    output logic                   busy
);

    tx_state_t              state;
    logic [1:0]             guard_cnt;
    logic                   launch;
    logic [UART_DATA_W-1:0] head;

    // Decided from registered empty/state, so a byte written this cycle
    // cannot be launched until the next one.
    assign launch = (state == S_IDLE) && !empty && tx_data_ready && !flush;
    assign busy   = !empty || (state != S_IDLE);

    sync_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (UART_DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (wr_en),
        .din   (wr_data),
        .pop   (launch),
        .dout  (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (flush) begin
            overflow <= 1'b0;
        end else if (wr_en && full && !launch) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            tx_data       <= '0;
            tx_data_valid <= 1'b0;
            guard_cnt     <= '0;
        end else begin
            tx_data_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        tx_data       <= head;
                        tx_data_valid <= 1'b1;
                        state         <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    guard_cnt <= 2'(GUARD_CYCLES - 1);
                    state     <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    // Terminal count means ready never dropped: assume the
                    // handshake was lost and return to idle.
                    if (!tx_data_ready) begin
                        state <= S_WAIT_HIGH;
                    end else if (guard_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        guard_cnt <= guard_cnt - 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (tx_data_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_ready;
    logic       busy;

    // Transmitter model controls
    logic model_en;
    logic model_ready;
    logic manual_ready;
    logic lost_mode;
    int   hold_len;
    int   hold_cnt;
    logic drop_pend;

    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;
    logic prev_valid = 1'b0;

    logic [7:0] launches[$];
    int         launch_cyc[$];

    assign tx_ready = model_en ? model_ready : manual_ready;

    always #5 clk = ~clk;

    uart_tx_fifo #(.ADDR_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .full          (full),
        .empty         (empty),
        .level         (level),
        .overflow      (overflow),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_ready),
        .busy          (busy)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Transmitter model: one cycle after seeing valid it drops ready,
    // holds it low for hold_len cycles, then raises it again.
    always @(negedge clk) begin
        if (!model_en) begin
            model_ready = 1'b1;
            drop_pend   = 1'b0;
            hold_cnt    = 0;
        end else begin
            if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) model_ready = 1'b1;
            end else if (drop_pend) begin
                drop_pend   = 1'b0;
                model_ready = 1'b0;
                hold_cnt    = hold_len;
            end
            if (tx_data_valid && !lost_mode) drop_pend = 1'b1;
        end
    end

    // Launch monitor
    always @(negedge clk) begin
        if (tx_data_valid) begin
            launches.push_back(tx_data);
            launch_cyc.push_back(cyc);
            check("valid_single_cycle", 16'(prev_valid), 16'd0);
            check("valid_with_ready", 16'(tx_ready), 16'd1);
        end
        prev_valid = tx_data_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max, input string name);
        int n = 0;
        while (!(empty && !busy) && n < max) begin
            step();
            n++;
        end
        check(name, 16'(empty && !busy), 16'd1);
    endtask

    typedef struct {
        logic       wr_en;
        logic       flush;
        logic [7:0] data;
        logic [4:0] e_level;
        logic       e_full;
        logic       e_empty;
        logic       e_ovf;
    } vec_t;

    vec_t tbl[20];

    initial begin
        // Fill 16 with the transmitter held busy, overflow, flush (which
        // beats a simultaneous write), write again, flush again.
        for (int i = 0; i < 16; i++)
            tbl[i] = '{1'b1, 1'b0, 8'(i + 1), 5'(i + 1), (i == 15), 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 8'h77, 5'd16, 1'b1, 1'b0, 1'b1};
        tbl[17] = '{1'b1, 1'b1, 8'h99, 5'd0,  1'b0, 1'b1, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 8'h3C, 5'd1,  1'b0, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 1'b1, 8'h00, 5'd0,  1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
        manual_ready = 1'b0; model_en = 1'b0; lost_mode = 1'b0; hold_len = 3;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        check("rst_empty", 16'(empty), 16'd1);
        check("rst_level", 16'(level), 16'd0);
        check("rst_valid", 16'(tx_data_valid), 16'd0);
        check("rst_busy",  16'(busy), 16'd0);
        check("rst_txdata", 16'(tx_data), 16'd0);

        // ---- table-driven vectors ----
        launches.delete();
        for (int i = 0; i < 20; i++) begin
            wr_en   = tbl[i].wr_en;
            flush   = tbl[i].flush;
            wr_data = tbl[i].data;
            step();
            check("tbl_level", 16'(level), 16'(tbl[i].e_level));
            check("tbl_full",  16'(full),  16'(tbl[i].e_full));
            check("tbl_empty", 16'(empty), 16'(tbl[i].e_empty));
            check("tbl_ovf",   16'(overflow), 16'(tbl[i].e_ovf));
            check("tbl_valid", 16'(tx_data_valid), 16'd0);
        end
        wr_en = 1'b0; flush = 1'b0;
        check("tbl_no_launch", 16'(launches.size()), 16'd0);

        // ---- reset mid-stream with overflow set and a frame in flight ----
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h40 + i);
            step();
        end
        wr_en = 1'b0;
        check("pre_rst_ovf", 16'(overflow), 16'd1);
        hold_len = 100; model_en = 1'b1;
        repeat (5) step();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("mid_rst_empty", 16'(empty), 16'd1);
        check("mid_rst_level", 16'(level), 16'd0);
        check("mid_rst_valid", 16'(tx_data_valid), 16'd0);
        check("mid_rst_ovf",   16'(overflow), 16'd0);
        check("mid_rst_busy",  16'(busy), 16'd0);
        check("mid_rst_txdata", 16'(tx_data), 16'd0);
        model_en = 1'b0;
        repeat (2) step();

        // ---- single byte latency ----
        launches.delete();
        hold_len = 100; model_en = 1'b1;
        wr_en = 1'b1; wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        check("lat_valid_c1", 16'(tx_data_valid), 16'd0);
        step();
        check("lat_valid_c2", 16'(tx_data_valid), 16'd1);
        check("lat_data", 16'(tx_data), 16'h00A5);
        step();
        check("lat_valid_c3", 16'(tx_data_valid), 16'd0);
        check("lat_busy_frame", 16'(busy), 16'd1);
        wait_idle(300, "single_idle");
        check("single_count", 16'(launches.size()), 16'd1);
        check("single_hold_data", 16'(tx_data), 16'h00A5);

        // ---- burst and order ----
        model_en = 1'b0; manual_ready = 1'b0;
        launches.delete();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i + 1);
            step();
        end
        wr_en = 1'b0;
        check("burst_level", 16'(level), 16'd16);
        check("burst_full", 16'(full), 16'd1);
        hold_len = 3; model_en = 1'b1;
        wait_idle(600, "burst_drain");
        check("burst_count", 16'(launches.size()), 16'd16);
        for (int i = 0; i < 16 && i < launches.size(); i++)
            check("burst_order", 16'(launches[i]), 16'(i + 1));
        check("burst_empty", 16'(empty), 16'd1);

        // ---- simultaneous push and pop at full ----
        model_en = 1'b0; manual_ready = 1'b0;
        launches.delete();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h20 + i);
            step();
        end
        check("pp_prefill", 16'(level), 16'd16);
        wr_en = 1'b1; wr_data = 8'hEE; model_en = 1'b1;
        step();
        wr_en = 1'b0;
        check("pp_level", 16'(level), 16'd16);
        check("pp_ovf", 16'(overflow), 16'd0);
        check("pp_valid", 16'(tx_data_valid), 16'd1);
        check("pp_data", 16'(tx_data), 16'h0020);
        wait_idle(600, "pp_drain");
        check("pp_count", 16'(launches.size()), 16'd17);
        for (int i = 0; i < 16 && i < launches.size(); i++)
            check("pp_order", 16'(launches[i]), 16'(8'h20 + i));
        if (launches.size() == 17)
            check("pp_last", 16'(launches[16]), 16'h00EE);

        // ---- lost handshake: ready never drops ----
        // Launch L, two guard cycles in S_WAIT_LOW, S_IDLE at L+3, next pulse at L+4.
        launches.delete(); launch_cyc.delete();
        lost_mode = 1'b1; model_en = 1'b1;
        wr_en = 1'b1; wr_data = 8'h55;
        step();
        wr_data = 8'h66;
        step();
        wr_en = 1'b0;
        wait_idle(60, "lost_idle");
        check("lost_count", 16'(launches.size()), 16'd2);
        if (launches.size() == 2) begin
            check("lost_first", 16'(launches[0]), 16'h0055);
            check("lost_second", 16'(launches[1]), 16'h0066);
            check("lost_gap", 16'(launch_cyc[1] - launch_cyc[0]), 16'd4);
        end
        lost_mode = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
